computer_system_gpio_pio: RTL and testbench
===========================================

// Module: computer_system_gpio_pio
// PURPOSE
//  Parametrised Avalon-MM general-purpose I/O slave. Successor to the fixed 8-bit output-only PIO.
//  Adds per-bit direction, atomic set/clear/toggle writes, input synchronisation, edge capture and a maskable IRQ.
//  Sits on the system interconnect as an s1 slave; out_port/oe_port drive top-level tristates; in_port is the pad readback.
// PARAMETERS
//  WIDTH        8    number of GPIO bits (1..32)
//  RESET_VALUE  0    data_out value loaded on reset (WIDTH bits)
//  RESET_DIR    0    direction value loaded on reset (1 = output)
//  EDGE_TYPE    0    capture on 0 = rising, 1 = falling, 2 = any edge
//  SYNC_STAGES  2    input synchroniser depth (>= 2)
// PORTS
//  clk          in   1      system clock
//  reset_n      in   1      synchronous active-low reset
//  address      in   3      register select
//  chipselect   in   1      slave select
//  write_n      in   1      active-low write strobe
//  writedata    in   32     write data; bits [WIDTH-1:0] used
//  readdata     out  32     read data, zero-extended above WIDTH
//  in_port      in   WIDTH  asynchronous pad inputs
//  out_port     out  WIDTH  output data register
//  oe_port      out  WIDTH  per-bit output enable (= direction register)
//  irq          out  1      interrupt, level, active-high
// BEHAVIOUR
//  One clock; reset is synchronous and active-low, sampled on rising clk only.
//  Reset: data_out=RESET_VALUE, dir=RESET_DIR, irq_mask=0, edge_cap=0, sync chain=0, prev=0; irq=0.
//  wr = chipselect & ~write_n. Register map (address):
//   0 DATA     R: (dir & data_out) | (~dir & in_sync); W: data_out <= wd
//   1 DIR      R/W direction; 1 = output
//   2 IRQMASK  R/W per-bit interrupt enable
//   3 EDGECAP  R: captured edges; W: write-1-to-clear per bit
//   4 OUTSET   W: data_out <= data_out | wd;   R: 0
//   5 OUTCLR   W: data_out <= data_out & ~wd;  R: 0
//   6 OUTTGL   W: data_out <= data_out ^ wd;   R: 0
//   7 reserved R: 0, writes ignored
//  readdata combinational from registers: zero wait, zero read latency; no read side effects.
//  Writes take effect at the clk edge of the write cycle; visible on out_port/oe_port the next cycle.
//  Synchroniser: in_port -> SYNC_STAGES flops -> in_sync; prev <= in_sync each cycle.
//  Pin change reaches DATA readback after SYNC_STAGES cycles; edge_cap bit sets 1 cycle later.
//  Edge detect: rising = in_sync & ~prev; falling = ~in_sync & prev; any = in_sync ^ prev.
//  Edge capture runs on all bits regardless of dir (output bits see pad loopback).
//  Edge and W1C clear on same bit, same cycle: set wins (edge not lost).
//  irq = |(edge_cap & irq_mask), registered: asserts 1 cycle after the capture/mask update; falls 1 cycle after clear.
//  Writes to an unselected address, or with chipselect=0, change nothing.
//  Reset asserted mid-operation: all state returns to reset values at that edge; pending edges discarded.
//  writedata bits >= WIDTH ignored; readdata bits >= WIDTH always 0.
// TESTING
//  1 Reset, WIDTH=8, RESET_VALUE=0xA5 -> out_port=0xA5, oe_port=0, irq=0, read addr3=0.
//  2 wr DIR=0x0F, DATA=0x3C, OUTSET=0x81, OUTCLR=0x04, OUTTGL=0xFF -> out_port 0x3C,0xBD,0xB9,0x46; in_port=0xF0, read DATA -> 0xF6.
//  3 EDGE_TYPE=0, mask=0x01, in_port[0] 0->1 -> edge_cap=0x01 at cycle 3, irq=1 at cycle 4; W1C 0x01 -> irq=0 next cycle.
//  4 Rising edge on bit 2 in same cycle as W1C 0x04 -> edge_cap[2] remains 1.
//  5 EDGE_TYPE=2, toggle in_port[5] twice, 10 cycles apart -> edge_cap[5]=1 after each; falling ignored when EDGE_TYPE=0.
//  6 reset_n low one cycle with edge_cap=0xFF, irq=1 -> next cycle all registers at reset values, irq=0.

Source files
------------

// File: rtl/computer_system_gpio_pio.sv
// Avalon-MM GPIO slave: per-bit direction, atomic set/clear/toggle, synchronised inputs,
// edge capture with write-1-to-clear and a maskable, registered level interrupt.

module computer_system_gpio_pio_bit #(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pad,
    input  logic cap_clr,
    output logic in_sync,
    output logic edge_cap
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev;
    logic                   edge_hit;

    assign in_sync  = sync_q[SYNC_STAGES-1];
    assign edge_hit = (EDGE_TYPE == 1) ? (~in_sync & prev) :
                      (EDGE_TYPE == 2) ? (in_sync ^ prev)  :
                                         (in_sync & ~prev);

    // A new edge overrides a same-cycle clear so no event is lost.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q   <= '0;
            prev     <= 1'b0;
            edge_cap <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pad};
            prev     <= in_sync;
            edge_cap <= (edge_cap & ~cap_clr) | edge_hit;
        end
    end
endmodule

module computer_system_gpio_pio #(
    parameter int          WIDTH       = 8,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter logic [31:0] RESET_DIR   = 32'h0,
    parameter int          EDGE_TYPE   = 0,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe_port,
    output logic             irq
);
    localparam logic [2:0] A_DATA = 3'd0;
    localparam logic [2:0] A_DIR  = 3'd1;
    localparam logic [2:0] A_MASK = 3'd2;
    localparam logic [2:0] A_EDGE = 3'd3;
    localparam logic [2:0] A_SET  = 3'd4;
    localparam logic [2:0] A_CLR  = 3'd5;
    localparam logic [2:0] A_TGL  = 3'd6;

    logic             wr;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] rd_w;
    logic             unused_wd;

    assign wr        = chipselect & ~write_n;
    assign wd        = writedata[WIDTH-1:0];
    assign unused_wd = ^writedata;
    assign cap_clr   = (wr && address == A_EDGE) ? wd : '0;

    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_bit
            computer_system_gpio_pio_bit #(
                .SYNC_STAGES(SYNC_STAGES),
                .EDGE_TYPE  (EDGE_TYPE)
            ) u_bit (
                .clk     (clk),
                .reset_n (reset_n),
                .pad     (in_port[i]),
                .cap_clr (cap_clr[i]),
                .in_sync (in_sync[i]),
                .edge_cap(edge_cap[i])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_out <= RESET_VALUE[WIDTH-1:0];
            dir      <= RESET_DIR[WIDTH-1:0];
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr) begin
                case (address)
                    A_DATA:  data_out <= wd;
                    A_DIR:   dir      <= wd;
                    A_MASK:  irq_mask <= wd;
                    A_SET:   data_out <= data_out | wd;
                    A_CLR:   data_out <= data_out & ~wd;
                    A_TGL:   data_out <= data_out ^ wd;
                    default: ;
                endcase
            end
            irq <= |(edge_cap & irq_mask);
        end
    end

    // Output pins read back the driven value; input pins read the synchronised pad.
    always_comb begin
        rd_w = '0;
        case (address)
            A_DATA:  rd_w = (dir & data_out) | (~dir & in_sync);
            A_DIR:   rd_w = dir;
            A_MASK:  rd_w = irq_mask;
            A_EDGE:  rd_w = edge_cap;
            default: rd_w = '0;
        endcase
    end

    assign readdata = 32'(rd_w);
    assign out_port = data_out;
    assign oe_port  = dir;
endmodule

// File: tb/tb_computer_system_gpio_pio.sv
// Directed bench: register-map vector table on a rising-edge instance, then hand-timed
// sequences for sync latency, irq timing, set-wins W1C, any-edge capture and mid-run reset.

module tb_computer_system_gpio_pio;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [7:0]  in_port = '0;
    logic [31:0] rd_r, rd_a;
    logic [7:0]  out_r, oe_r, out_a, oe_a;
    logic        irq_r, irq_a;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    computer_system_gpio_pio #(.WIDTH(8), .RESET_VALUE(32'hA5), .EDGE_TYPE(0)) dut_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_r), .in_port(in_port),
        .out_port(out_r), .oe_port(oe_r), .irq(irq_r));

    computer_system_gpio_pio #(.WIDTH(8), .EDGE_TYPE(2)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd_a), .in_port(in_port),
        .out_port(out_a), .oe_port(oe_a), .irq(irq_a));

    typedef struct {
        logic        is_wr;
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic [7:0]  exp_out;
        logic [7:0]  exp_oe;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    // Called at a negedge; the write lands on the next posedge and returns at the following negedge.
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        step(1);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 3'd1, 32'h0F,       32'h0,  8'hA5, 8'h0F};
        vecs[1]  = '{1'b1, 3'd0, 32'h3C,       32'h0,  8'h3C, 8'h0F};
        vecs[2]  = '{1'b1, 3'd4, 32'h81,       32'h0,  8'hBD, 8'h0F};
        vecs[3]  = '{1'b1, 3'd5, 32'h04,       32'h0,  8'hB9, 8'h0F};
        vecs[4]  = '{1'b1, 3'd6, 32'hFF,       32'h0,  8'h46, 8'h0F};
        vecs[5]  = '{1'b0, 3'd1, 32'h0,        32'h0F, 8'h46, 8'h0F};
        vecs[6]  = '{1'b0, 3'd0, 32'h0,        32'h06, 8'h46, 8'h0F};
        vecs[7]  = '{1'b0, 3'd4, 32'h0,        32'h0,  8'h46, 8'h0F};
        vecs[8]  = '{1'b1, 3'd7, 32'hFF,       32'h0,  8'h46, 8'h0F};
        vecs[9]  = '{1'b0, 3'd7, 32'h0,        32'h0,  8'h46, 8'h0F};
        vecs[10] = '{1'b1, 3'd0, 32'hFFFFFF00, 32'h0,  8'h00, 8'h0F};
        vecs[11] = '{1'b1, 3'd0, 32'h46,       32'h0,  8'h46, 8'h0F};
        vecs[12] = '{1'b1, 3'd2, 32'h101,      32'h0,  8'h46, 8'h0F};
        vecs[13] = '{1'b0, 3'd2, 32'h0,        32'h01, 8'h46, 8'h0F};

        // Reset state
        step(3);
        chk("reset_out", 32'(out_r), 32'hA5);
        chk("reset_oe", 32'(oe_r), 32'h0);
        chk("reset_irq", 32'(irq_r), 32'h0);
        rd(3'd3);
        chk("reset_edgecap", rd_r, 32'h0);
        reset_n = 1'b1;
        chipselect = 1'b0;
        step(1);

        for (int v = 0; v < 14; v++) begin
            if (vecs[v].is_wr) begin
                wr(vecs[v].addr, vecs[v].wd);
            end else begin
                rd(vecs[v].addr);
                chk($sformatf("vec%0d_rd", v), rd_r, vecs[v].exp_rd);
                chipselect = 1'b0;
                step(1);
            end
            chk($sformatf("vec%0d_out", v), 32'(out_r), 32'(vecs[v].exp_out));
            chk($sformatf("vec%0d_oe", v), 32'(oe_r), 32'(vecs[v].exp_oe));
        end

        // Write with chipselect low is ignored
        address = 3'd0; writedata = 32'h0; chipselect = 1'b0; write_n = 1'b0;
        step(1);
        write_n = 1'b1;
        chk("nocs_out", 32'(out_r), 32'h46);

        // Mixed direction readback
        in_port = 8'hF0;
        step(3);
        rd(3'd0);
        chk("data_mixed", rd_r, 32'hF6);
        wr(3'd3, 32'hFF);
        rd(3'd3);
        chk("w1c_all", rd_r, 32'h0);
        chipselect = 1'b0;

        // Rising edge on bit 0: sync latency, capture, registered irq, clear
        in_port = 8'hF1;
        step(2);
        rd(3'd0);
        chk("sync_visible", rd_r, 32'hF6);
        rd(3'd3);
        chk("cap_not_yet", rd_r, 32'h0);
        step(1);
        chk("cap_cycle3", rd_r, 32'h01);
        chk("irq_not_yet", 32'(irq_r), 32'h0);
        step(1);
        chk("irq_cycle4", 32'(irq_r), 32'h1);
        wr(3'd3, 32'h01);
        rd(3'd3);
        chk("cap_cleared", rd_r, 32'h0);
        chk("irq_lag", 32'(irq_r), 32'h1);
        step(1);
        chk("irq_fall", 32'(irq_r), 32'h0);
        chipselect = 1'b0;

        // Edge and W1C on the same bit in the same cycle: set wins
        in_port = 8'hF5;
        step(2);
        wr(3'd3, 32'h04);
        rd(3'd3);
        chk("set_wins", rd_r, 32'h04);
        chipselect = 1'b0;
        wr(3'd3, 32'h04);
        rd(3'd3);
        chk("w1c_bit2", rd_r, 32'h0);
        chipselect = 1'b0;
        wr(3'd3, 32'hFF);

        // Any-edge capture on bit 5, falling ignored on the rising instance
        in_port = 8'hD5;
        step(4);
        rd(3'd3);
        chk("any_fall", rd_a & 32'h20, 32'h20);
        chk("rise_ignores_fall", rd_r & 32'h20, 32'h0);
        chipselect = 1'b0;
        wr(3'd3, 32'h20);
        step(5);
        in_port = 8'hF5;
        step(4);
        rd(3'd3);
        chk("any_rise", rd_a & 32'h20, 32'h20);
        chk("rise_rise", rd_r & 32'h20, 32'h20);
        chipselect = 1'b0;

        // Mid-run reset with all edges captured and irq high
        in_port = 8'h00;
        step(4);
        wr(3'd3, 32'hFF);
        in_port = 8'hFF;
        step(4);
        wr(3'd2, 32'hFF);
        rd(3'd3);
        chk("all_captured", rd_r, 32'hFF);
        chipselect = 1'b0;
        step(1);
        chk("irq_all", 32'(irq_r), 32'h1);
        reset_n = 1'b0;
        step(1);
        reset_n = 1'b1;
        chk("rst2_out", 32'(out_r), 32'hA5);
        chk("rst2_oe", 32'(oe_r), 32'h0);
        chk("rst2_irq", 32'(irq_r), 32'h0);
        rd(3'd3);
        chk("rst2_edgecap", rd_r, 32'h0);
        rd(3'd2);
        chk("rst2_mask", rd_r, 32'h0);
        chipselect = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
